// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: datapath width, wait-counter width and the
// memory-interface FSM state encoding.
package lc3_pkg;

    localparam int DATA_W = 16;
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/lc3_wait_cnt.sv
// Memory wait-cycle counter. tc flags the last cycle allowed before a timeout,
// so that cycle's mem_ack can still win.
module lc3_wait_cnt
    import lc3_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

    assign tc = (cnt == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR memory interface: loads MAR/MDR from the bus, runs one memory
// access per mio_en, pulses r on completion and flags timeouts on err.
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    output logic [DATA_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic              r,
    output logic              err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output state_t            state_dbg
);

    // Memory handshake: mem_req is held high from the first ACCESS cycle until
    // the cycle mem_ack is sampled high (or the wait budget runs out); mem_ack
    // is only looked at while mem_req is high, and address/data are held stable
    // for the whole request because MAR/MDR are frozen while busy.
    state_t state;
    logic   wr_flag;
    logic   wait_clr;
    logic   wait_en;
    logic   wait_tc;

    assign wait_clr = (state == IDLE) && mio_en;
    assign wait_en  = (state == ACCESS) && !mem_ack;

    lc3_wait_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_cnt (
        .clk(clk),
        .rst(rst),
        .clr(wait_clr),
        .en (wait_en),
        .tc (wait_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            wr_flag <= 1'b0;
            err     <= 1'b0;
            r       <= 1'b0;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            r <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_mar) mar <= bus_in;
                    if (ld_mdr) mdr <= bus_in;
                    if (mio_en) begin
                        wr_flag <= r_w;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        mem_we  <= r_w;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack in the final budget cycle takes priority over the timeout.
                    if (mem_ack) begin
                        if (!wr_flag) mdr <= mem_rdata;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        r       <= 1'b1;
                        state   <= DONE;
                    end else if (wait_tc) begin
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        r       <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign state_dbg = state;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Testbench for lc3_mem_if: directed and random accesses checked against an
// access-level reference model (latency, data result, sticky error).
module tb_lc3_mem_if;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [15:0] bus_in;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        r_w;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        r;
    logic        err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    lc3_pkg::state_t state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic        m_err;

    lc3_mem_if #(
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_in   (bus_in),
        .ld_mar   (ld_mar),
        .ld_mdr   (ld_mdr),
        .mio_en   (mio_en),
        .r_w      (r_w),
        .mar      (mar),
        .mdr      (mdr),
        .r        (r),
        .err      (err),
        .busy     (busy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access: load MAR/MDR, pulse mio_en, act as memory acking
    // after 'delay' wait cycles, and check the outcome against the model.
    task automatic do_access(input string tag, input logic [15:0] addr, input logic [15:0] data,
                             input logic w, input int delay, input logic [15:0] rdata,
                             input logic poke_busy);
        int          exp_lat;
        logic [15:0] exp_mdr;
        int          r_cycle;
        int          r_count;
        int          we_count;
        int          req_count;
        int          busy_count;
        logic        stable;
        // model: an ack within the budget completes, otherwise timeout
        if (delay < TO) begin
            exp_lat = delay + 2;
            exp_mdr = w ? data : rdata;
        end else begin
            exp_lat = TO + 1;
            exp_mdr = data;
            m_err   = 1'b1;
        end
        @(negedge clk);
        bus_in = addr; ld_mar = 1'b1;
        @(negedge clk);
        bus_in = data; ld_mar = 1'b0; ld_mdr = 1'b1;
        @(negedge clk);
        ld_mdr = 1'b0; r_w = w; mio_en = 1'b1;
        r_cycle = 0; r_count = 0; we_count = 0; req_count = 0; busy_count = 0; stable = 1'b1;
        for (int k = 1; k <= exp_lat + 2; k++) begin
            @(negedge clk);
            mio_en = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
            if (r) begin
                r_count++;
                if (r_cycle == 0) r_cycle = k;
            end
            if (mem_we) we_count++;
            if (mem_req) req_count++;
            if (busy) busy_count++;
            if (mem_req && (mem_addr !== addr || mem_wdata !== data)) stable = 1'b0;
            if (poke_busy && k == 1) begin
                bus_in = 16'h1234; ld_mar = 1'b1; ld_mdr = 1'b1; mio_en = 1'b1; r_w = ~w;
            end
            mem_ack   = (k == delay + 1);
            mem_rdata = (k == delay + 1) ? rdata : 16'($urandom);
        end
        mem_ack = 1'b0;
        check({tag, " r_latency"}, 32'(r_cycle), 32'(exp_lat));
        check({tag, " r_pulses"}, 32'(r_count), 32'd1);
        check({tag, " req_cycles"}, 32'(req_count), 32'(exp_lat - 1));
        check({tag, " we_cycles"}, 32'(we_count), w ? 32'(exp_lat - 1) : 32'd0);
        check({tag, " busy_cycles"}, 32'(busy_count), 32'(exp_lat));
        check({tag, " addr_data_stable"}, 32'(stable), 32'd1);
        check({tag, " mar"}, 32'(mar), 32'(addr));
        check({tag, " mdr"}, 32'(mdr), 32'(exp_mdr));
        check({tag, " err"}, 32'(err), 32'(m_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mar"}, 32'(mar), 32'd0);
        check({tag, " mdr"}, 32'(mdr), 32'd0);
        check({tag, " r"}, 32'(r), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " mem_req"}, 32'(mem_req), 32'd0);
        check({tag, " mem_we"}, 32'(mem_we), 32'd0);
        check({tag, " state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        rst = 1'b0; bus_in = '0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
        r_w = 1'b0; mem_rdata = '0; mem_ack = 1'b0; m_err = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // directed cases
        do_access("read0", 16'h3000, 16'h0000, 1'b0, 0, 16'hBEEF, 1'b0);
        do_access("write3", 16'hFE06, 16'h0041, 1'b1, 3, 16'hDEAD, 1'b0);
        do_access("ack_at_limit", 16'h2222, 16'h7777, 1'b0, TO - 1, 16'h5A5A, 1'b0);
        do_access("timeout", 16'h4000, 16'h1111, 1'b0, TO, 16'hCAFE, 1'b0);
        do_access("after_timeout", 16'h4001, 16'h2468, 1'b0, 1, 16'h1357, 1'b0);
        do_access("busy_block", 16'h0ABC, 16'h0DEF, 1'b0, 2, 16'h9999, 1'b1);

        // mem_ack while idle must not touch MDR
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        repeat (2) @(negedge clk);
        check("idle_ack mdr", 32'(mdr), 32'h9999);
        check("idle_ack busy", 32'(busy), 32'd0);
        mem_ack = 1'b0;

        // randomized accesses
        for (int i = 0; i < 20; i++) begin
            do_access($sformatf("rand%0d", i), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, TO + 2)),
                      16'($urandom), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of an access, then an access on the first edge
        @(negedge clk);
        bus_in = 16'h5555; ld_mar = 1'b1; r_w = 1'b0; mio_en = 1'b1;
        @(negedge clk);
        ld_mar = 1'b0; mio_en = 1'b0;
        @(negedge clk);
        check("pre_abort busy", 32'(busy), 32'd1);
        rst = 1'b0; m_err = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b1; mio_en = 1'b1; r_w = 1'b1;
        @(negedge clk);
        mio_en = 1'b0;
        check("post_rst busy", 32'(busy), 32'd1);
        check("post_rst mem_req", 32'(mem_req), 32'd1);
        check("post_rst mem_we", 32'(mem_we), 32'd1);
        check("post_rst addr", 32'(mem_addr), 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hABCD;
        @(negedge clk);
        mem_ack = 1'b0;
        check("post_rst r", 32'(r), 32'd1);
        check("post_rst mdr", 32'(mdr), 32'd0);
        @(negedge clk);
        check("post_rst idle", 32'(busy), 32'd0);
        check("post_rst err", 32'(err), 32'(m_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
